// File: rtl/inst_line_fetcher.sv
// Instruction cache line fetcher: turns one line request into LINE_WORDS word reads
// on the memory bus, with optional critical-word-first wrap inside the line.
//
// state | meaning
// IDLE  | waiting for rd_i from the cache refill port
// FETCH | word reads in flight, mem_rd_o high
// DONE  | ack_o pulse, line and fault flag valid
module inst_line_fetcher #(
    parameter int LINE_WORDS     = 8,
    parameter bit CRITICAL_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              addr_i,
    input  logic                     rd_i,
    output logic [LINE_WORDS*32-1:0] data_o,
    output logic                     ack_o,
    output logic                     hw_page_fault_o,
    output logic [31:0]              mem_addr_o,
    output logic                     mem_rd_o,
    input  logic [31:0]              mem_data_i,
    input  logic                     mem_ack_i,
    input  logic                     mem_page_fault_i
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] start_idx;
    logic             start;
    logic             word_ok;
    logic             fault_hit;
    logic             last_word;

    assign word_idx  = mem_addr_o[OFF_W-1:2];
    assign start_idx = CRITICAL_FIRST ? addr_i[OFF_W-1:2] : '0;
    assign start     = (state == IDLE) && rd_i;
    assign word_ok   = (state == FETCH) && mem_ack_i && !mem_page_fault_i;
    assign fault_hit = (state == FETCH) && mem_ack_i && mem_page_fault_i;
    assign last_word = (count == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_i) state_nxt = FETCH;
            FETCH:   if (fault_hit || (word_ok && last_word)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_o = (state == FETCH);
        ack_o    = (state == DONE);
    end

    // Only the word-index bits of mem_addr_o move, so the wrap stays inside the line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_o      <= '0;
            count           <= '0;
            data_o          <= '0;
            hw_page_fault_o <= 1'b0;
        end else begin
            if (start) begin
                mem_addr_o      <= {addr_i[31:OFF_W], start_idx, 2'b00};
                count           <= '0;
                hw_page_fault_o <= 1'b0;
            end
            if (fault_hit) begin
                hw_page_fault_o <= 1'b1;
            end
            if (word_ok) begin
                count <= count + IDX_W'(1);
                if (!last_word) begin
                    mem_addr_o[OFF_W-1:2] <= word_idx + IDX_W'(1);
                end
            end
            for (int w = 0; w < LINE_WORDS; w++) begin
                if (word_ok && (word_idx == IDX_W'(w))) begin
                    data_o[w*32 +: 32] <= mem_data_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_line_fetcher.sv
// Bench for inst_line_fetcher: one critical-first and one linear instance share stimulus
// and are checked every cycle against a word-list model of the line fill.
module tb_inst_line_fetcher;
    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_i;
    logic [31:0] addr_i;
    logic        mem_ack_i;
    logic        mem_pf_i;
    logic [31:0] md[2];

    logic [255:0] data_w[2];
    logic         ack_w[2];
    logic         pf_w[2];
    logic         mrd_w[2];
    logic [31:0]  maddr_w[2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inst_line_fetcher #(.LINE_WORDS(LW), .CRITICAL_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .rd_i(rd_i),
        .data_o(data_w[0]), .ack_o(ack_w[0]), .hw_page_fault_o(pf_w[0]),
        .mem_addr_o(maddr_w[0]), .mem_rd_o(mrd_w[0]), .mem_data_i(md[0]),
        .mem_ack_i(mem_ack_i), .mem_page_fault_i(mem_pf_i));

    inst_line_fetcher #(.LINE_WORDS(LW), .CRITICAL_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .rd_i(rd_i),
        .data_o(data_w[1]), .ack_o(ack_w[1]), .hw_page_fault_o(pf_w[1]),
        .mem_addr_o(maddr_w[1]), .mem_rd_o(mrd_w[1]), .mem_data_i(md[1]),
        .mem_ack_i(mem_ack_i), .mem_page_fault_i(mem_pf_i));

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: configurable wait states, fault on the n-th ack, spurious idle acks.
    int          wfix = 0, wmax = 0, fault_at = 0, ackn = 0, wcnt = 0, wait_cur = 0;
    bit          wrand = 1'b0, spur = 1'b0;
    logic [31:0] key = '0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    function automatic int next_wait();
        return wrand ? int'($urandom_range(0, wmax)) : wfix;
    endfunction

    initial begin
        mem_ack_i = 1'b0;
        mem_pf_i  = 1'b0;
        md[0]     = '0;
        md[1]     = '0;
    end

    always @(negedge clk) begin
        if (mrd_w[0]) begin
            if (wcnt < wait_cur) begin
                mem_ack_i = 1'b0;
                mem_pf_i  = 1'b0;
                wcnt++;
            end else begin
                ackn++;
                mem_ack_i = 1'b1;
                mem_pf_i  = (ackn == fault_at);
                md[0]     = maddr_w[0] ^ key;
                md[1]     = maddr_w[1] ^ key;
                q0.push_back(maddr_w[0]);
                q1.push_back(maddr_w[1]);
                wcnt     = 0;
                wait_cur = next_wait();
            end
        end else begin
            ackn      = 0;
            wcnt      = 0;
            wait_cur  = next_wait();
            mem_ack_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_pf_i  = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            md[0]     = $urandom;
            md[1]     = $urandom;
        end
    end

    // Reference model: a fill is a list of word slots (start + n) mod LW taken in order.
    logic        m_busy[2], m_done[2], m_fault[2];
    int          m_n[2], m_s[2];
    logic [31:0] m_base[2], m_addr[2];
    logic [31:0] m_line[2][LW];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d]  = 1'b0;
                m_done[d]  = 1'b0;
                m_fault[d] = 1'b0;
                m_addr[d]  = '0;
                m_n[d]     = 0;
                for (int w = 0; w < LW; w++) m_line[d][w] = '0;
            end else if (m_done[d]) begin
                m_done[d] = 1'b0;
            end else if (!m_busy[d]) begin
                if (rd_i) begin
                    m_base[d]  = {addr_i[31:5], 5'b0};
                    m_s[d]     = (d == 0) ? int'(addr_i[4:2]) : 0;
                    m_n[d]     = 0;
                    m_fault[d] = 1'b0;
                    m_busy[d]  = 1'b1;
                    m_addr[d]  = m_base[d] + 32'(4 * m_s[d]);
                end
            end else if (mem_ack_i) begin
                if (mem_pf_i) begin
                    m_fault[d] = 1'b1;
                    m_busy[d]  = 1'b0;
                    m_done[d]  = 1'b1;
                end else begin
                    m_line[d][(m_s[d] + m_n[d]) % LW] = md[d];
                    m_n[d]++;
                    if (m_n[d] == LW) begin
                        m_busy[d] = 1'b0;
                        m_done[d] = 1'b1;
                    end else begin
                        m_addr[d] = m_base[d] + 32'(4 * ((m_s[d] + m_n[d]) % LW));
                    end
                end
            end
        end
    end

    function automatic logic [255:0] model_line(input int d);
        logic [255:0] r;
        for (int w = 0; w < LW; w++) r[w*32 +: 32] = m_line[d][w];
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("mem_rd_o[%0d]", d), 256'(mrd_w[d]), 256'(m_busy[d]));
                chk($sformatf("ack_o[%0d]", d), 256'(ack_w[d]), 256'(m_done[d]));
                chk($sformatf("fault[%0d]", d), 256'(pf_w[d]), 256'(m_fault[d]));
                chk($sformatf("mem_addr_o[%0d]", d), 256'(maddr_w[d]), 256'(m_addr[d]));
                chk($sformatf("data_o[%0d]", d), data_w[d], model_line(d));
            end
        end
    end

    // Stimulus helpers; all called at a falling edge.
    task automatic start_fill(input logic [31:0] a, output int k);
        addr_i = a;
        rd_i   = 1'b1;
        k      = cyc + 1;
    endtask

    // ac is the number of the clock edge that closes the ack_o cycle.
    task automatic wait_ack(input int drop_after, output int ac);
        ac = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (drop_after == i) rd_i = 1'b0;
            if (ack_w[0]) begin
                ac   = cyc + 1;
                rd_i = 1'b0;
                break;
            end
        end
        if (ac < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack_o, expected one within 400 cycles");
        end
    endtask

    initial begin
        int          k, ac, a1;
        logic [31:0] k1, k2;
        logic [255:0] exp;

        rst_n  = 1'b0;
        rd_i   = 1'b0;
        addr_i = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_data", data_w[0], '0);
        chk("reset_ack", 256'(ack_w[0]), 256'(0));
        chk("reset_mem_rd", 256'(mrd_w[0]), 256'(0));
        chk("reset_mem_addr", 256'(maddr_w[1]), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: critical-first, zero wait, data equals address
        key = '0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        start_fill(32'h0000_1234, k);
        wait_ack(0, ac);
        chk("t1_ack_cycle", 256'(ac), 256'(k + 9));
        chk("t1_req_count", 256'(q0.size()), 256'(8));
        if (q0.size() == 8) begin
            chk("t1_addr0", 256'(q0[0]), 256'(32'h1234));
            chk("t1_addr2", 256'(q0[2]), 256'(32'h123C));
            chk("t1_addr3_wrap", 256'(q0[3]), 256'(32'h1220));
            chk("t1_addr7", 256'(q0[7]), 256'(32'h1230));
        end
        for (int w = 0; w < LW; w++) exp[w*32 +: 32] = 32'h1220 + 32'(4 * w);
        chk("t1_line", data_w[0], exp);
        chk("t1_fault", 256'(pf_w[0]), 256'(0));

        // 2: linear fill, two wait cycles per word
        wfix = 2;
        q1.delete();
        @(negedge clk);
        start_fill(32'h0000_401C, k);
        wait_ack(0, ac);
        chk("t2_ack_cycle", 256'(ac), 256'(k + 25));
        chk("t2_req_count", 256'(q1.size()), 256'(8));
        if (q1.size() == 8) begin
            chk("t2_addr0", 256'(q1[0]), 256'(32'h4000));
            chk("t2_addr7", 256'(q1[7]), 256'(32'h401C));
        end

        // 3: fault on third ack leaves words 2..7 from the previous fill
        wfix = 0;
        k1   = 32'hA5A5_0000;
        k2   = 32'h5A5A_0000;
        key  = k1;
        @(negedge clk);
        start_fill(32'h0000_8000, k);
        wait_ack(0, ac);
        key      = k2;
        fault_at = 3;
        q1.delete();
        @(negedge clk);
        start_fill(32'h0000_8000, k);
        wait_ack(0, ac);
        chk("t3_req_count", 256'(q1.size()), 256'(3));
        chk("t3_fault", 256'(pf_w[1]), 256'(1));
        for (int w = 0; w < LW; w++)
            exp[w*32 +: 32] = (32'h8000 + 32'(4 * w)) ^ ((w < 2) ? k2 : k1);
        chk("t3_line", data_w[1], exp);
        fault_at = 0;

        // 4: reset during the fifth word wait
        wfix = 2;
        key  = 32'h0F0F_F0F0;
        q0.delete();
        @(negedge clk);
        start_fill(32'h0000_6000, k);
        for (int i = 0; i < 100 && q0.size() < 4; i++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        rd_i  = 1'b0;
        @(negedge clk);
        chk("t4_mem_rd", 256'(mrd_w[0]), 256'(0));
        chk("t4_data", data_w[0], '0);
        chk("t4_ack", 256'(ack_w[0]), 256'(0));
        rst_n = 1'b1;
        wfix  = 1;
        repeat (2) @(negedge clk);
        start_fill(32'h0000_2468, k);
        wait_ack(0, ac);
        for (int w = 0; w < LW; w++) exp[w*32 +: 32] = (32'h2460 + 32'(4 * w)) ^ key;
        chk("t4_refill_line", data_w[0], exp);

        // 5: faulted fill then back-to-back fill one idle cycle later
        wfix     = 0;
        fault_at = 2;
        @(negedge clk);
        start_fill(32'h0000_3000, k);
        wait_ack(0, a1);
        @(negedge clk);
        fault_at = 0;
        chk("t5_idle_mem_rd", 256'(mrd_w[0]), 256'(0));
        chk("t5_fault_held", 256'(pf_w[0]), 256'(1));
        start_fill(32'h0000_3100, k);
        chk("t5_gap", 256'(k), 256'(a1 + 1));
        @(negedge clk);
        chk("t5_fetch_mem_rd", 256'(mrd_w[0]), 256'(1));
        chk("t5_fault_cleared", 256'(pf_w[0]), 256'(0));
        wait_ack(0, ac);

        // 6: spurious idle acks, then rd_i dropped mid-fill
        spur = 1'b1;
        repeat (10) @(negedge clk);
        start_fill(32'h5555_5550, k);
        wait_ack(3, ac);
        chk("t6_ack_cycle", 256'(ac), 256'(k + 9));
        repeat (5) @(negedge clk);

        // Randomised fills
        wrand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            wmax     = $urandom_range(0, 3);
            key      = $urandom;
            spur     = 1'($urandom_range(0, 1));
            fault_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LW)) : 0;
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
            start_fill($urandom, k);
            if ($urandom_range(0, 9) == 0) begin
                repeat (1 + $urandom_range(0, 10)) @(negedge clk);
                rst_n = 1'b0;
                rd_i  = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                wait_ack(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : 0, ac);
            end
        end
        spur = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
